// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive-side drain logic.
//   drain_state_t : sequencing states of the RX FIFO drain controller
//   DATA_BITS_DEF : default received data word width
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LOAD    = 2'd2,
        PRESENT = 2'd3
    } drain_state_t;

    localparam int DATA_BITS_DEF = 8;

endpackage : uart_pkg

// File: rtl/rx_timeout_timer.sv
// ---------------------------------------------------------------------------
// rx_timeout_timer
// Saturating character-timeout counter. Counts idle clocks while data sits
// in the RX FIFO and flags expiry once TIMEOUT_CYCLES clocks have elapsed.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clear   : restart the idle interval (takes priority over count)
//   count   : advance the idle interval by one clock
//   expired : high while the counter sits at TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == LIMIT) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            timer <= '0;
        end else if (count) begin
            timer <= sat_inc(timer);
        end
    end

    // Decoded from the registered count, so expiry falls in the cycle
    // right after any clear.
    assign expired = (timer == LIMIT);

endmodule : rx_timeout_timer

// File: rtl/rx_fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// rx_fifo_drain_ctrl
// Drains the UART RX FIFO onto a valid/ready host interface and generates
// the receive interrupts.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   drain_en        : host permits draining
//   fifo_empty      : FIFO empty flag
//   fifo_full       : FIFO half-full-or-more flag
//   fifo_overflow   : FIFO completely-full flag
//   fifo_data       : FIFO registered read data (valid the cycle after a pop)
//   rx_data_rdy     : receiver write strobe into the FIFO
//   bist_mode       : FIFO in BIST, all traffic ignored
//   fifo_pop        : pop strobe to the FIFO
//   host_data       : byte held for the host
//   host_valid      : host_data valid
//   host_ready      : host accepts host_data
//   ovf_clr         : clears irq_overflow and drop_count
//   irq_data        : registered copy of fifo_full
//   irq_timeout     : character timeout interrupt
//   irq_overflow    : sticky dropped-byte interrupt
//   drop_count      : saturating dropped-byte counter
// ---------------------------------------------------------------------------
module rx_fifo_drain_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = DATA_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DROP_CNT_BITS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     drain_en,
    input  logic                     fifo_empty,
    input  logic                     fifo_full,
    input  logic                     fifo_overflow,
    input  logic [DATA_BITS-1:0]     fifo_data,
    input  logic                     rx_data_rdy,
    input  logic                     bist_mode,
    output logic                     fifo_pop,
    output logic [DATA_BITS-1:0]     host_data,
    output logic                     host_valid,
    input  logic                     host_ready,
    input  logic                     ovf_clr,
    output logic                     irq_data,
    output logic                     irq_timeout,
    output logic                     irq_overflow,
    output logic [DROP_CNT_BITS-1:0] drop_count
);

    drain_state_t state, state_nxt;
    logic         can_drain;
    logic         drop_evt;

    function automatic logic [DROP_CNT_BITS-1:0] sat_inc(input logic [DROP_CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign can_drain = drain_en && !fifo_empty && !bist_mode;
    assign drop_evt  = rx_data_rdy && fifo_overflow && !bist_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The FIFO lets a write beat a pop, so a pop is only issued in a cycle
    // without a write strobe; otherwise it is simply retried next cycle.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_drain) state_nxt = ISSUE;
            end
            ISSUE: begin
                fifo_pop = !rx_data_rdy && !bist_mode;
                if (fifo_pop) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (host_valid && host_ready) state_nxt = can_drain ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // LOAD is the cycle the FIFO's registered read data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_data  <= '0;
            host_valid <= 1'b0;
        end else if (state == LOAD) begin
            host_data  <= fifo_data;
            host_valid <= 1'b1;
        end else if (state == PRESENT && host_ready) begin
            host_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_data <= 1'b0;
        end else begin
            irq_data <= fifo_full;
        end
    end

    // A drop coinciding with a clear counts as the first drop after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_overflow <= 1'b0;
            drop_count   <= '0;
        end else if (ovf_clr) begin
            irq_overflow <= drop_evt;
            drop_count   <= drop_evt ? DROP_CNT_BITS'(1) : '0;
        end else if (drop_evt) begin
            irq_overflow <= 1'b1;
            drop_count   <= sat_inc(drop_count);
        end
    end

    rx_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (fifo_empty || rx_data_rdy || fifo_pop || bist_mode),
        .count   (!fifo_empty),
        .expired (irq_timeout)
    );

endmodule : rx_fifo_drain_ctrl

// File: tb/tb_rx_fifo_drain_ctrl.sv
module tb_rx_fifo_drain_ctrl;

    localparam int DW   = 8;
    localparam int TO   = 8;
    localparam int DCW  = 8;
    localparam int FDEP = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           drain_en;
    logic           fifo_empty;
    logic           fifo_full;
    logic           fifo_overflow;
    logic [DW-1:0]  fifo_data;
    logic           rx_data_rdy;
    logic           bist_mode;
    logic           fifo_pop;
    logic [DW-1:0]  host_data;
    logic           host_valid;
    logic           host_ready;
    logic           ovf_clr;
    logic           irq_data;
    logic           irq_timeout;
    logic           irq_overflow;
    logic [DCW-1:0] drop_count;

    logic [DW-1:0]  rx_wdata;
    logic [DW-1:0]  fmem [FDEP];
    int             fcount, rd_ptr, wr_ptr;

    int             n_chk = 0;
    int             n_err = 0;
    logic [DW-1:0]  sb_q[$];

    always #5 clk = ~clk;

    rx_fifo_drain_ctrl #(
        .DATA_BITS      (DW),
        .TIMEOUT_CYCLES (TO),
        .DROP_CNT_BITS  (DCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .drain_en      (drain_en),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_overflow (fifo_overflow),
        .fifo_data     (fifo_data),
        .rx_data_rdy   (rx_data_rdy),
        .bist_mode     (bist_mode),
        .fifo_pop      (fifo_pop),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .ovf_clr       (ovf_clr),
        .irq_data      (irq_data),
        .irq_timeout   (irq_timeout),
        .irq_overflow  (irq_overflow),
        .drop_count    (drop_count)
    );

    // 16-entry RX FIFO model with registered read data; write beats pop.
    always @(posedge clk) begin
        if (rst) begin
            fcount    <= 0;
            rd_ptr    <= 0;
            wr_ptr    <= 0;
            fifo_data <= '0;
        end else if (!bist_mode) begin
            if (rx_data_rdy) begin
                if (fcount < FDEP) begin
                    fmem[wr_ptr] <= rx_wdata;
                    wr_ptr       <= (wr_ptr + 1) % FDEP;
                    fcount       <= fcount + 1;
                end
            end else if (fifo_pop && fcount > 0) begin
                fifo_data <= fmem[rd_ptr];
                rd_ptr    <= (rd_ptr + 1) % FDEP;
                fcount    <= fcount - 1;
            end
        end
    end

    assign fifo_empty    = (fcount == 0);
    assign fifo_full     = (fcount >= FDEP / 2);
    assign fifo_overflow = (fcount == FDEP);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake must deliver the oldest accepted byte.
    always @(negedge clk) begin
        if (!rst && host_valid && host_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_byte", {24'd0, host_data}, 32'hFFFF_FFFF);
            end else begin
                check("sb_data", {24'd0, host_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic push_byte(input logic [DW-1:0] b, input logic clr);
        @(posedge clk); #1;
        rx_data_rdy = 1'b1;
        rx_wdata    = b;
        ovf_clr     = clr;
        if (fcount < FDEP) sb_q.push_back(b);
        @(posedge clk); #1;
        rx_data_rdy = 1'b0;
        ovf_clr     = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || host_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (n < 300)}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!host_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, host_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; drain_en = 1'b0; rx_data_rdy = 1'b0; rx_wdata = '0;
        bist_mode = 1'b0; host_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid",    {31'd0, host_valid},   32'd0);
        check("rst_data",     {24'd0, host_data},    32'd0);
        check("rst_pop",      {31'd0, fifo_pop},     32'd0);
        check("rst_irq_data", {31'd0, irq_data},     32'd0);
        check("rst_irq_to",   {31'd0, irq_timeout},  32'd0);
        check("rst_irq_ovf",  {31'd0, irq_overflow}, 32'd0);
        check("rst_drops",    {24'd0, drop_count},   32'd0);

        // Single byte: pop to valid latency is two cycles, then back to idle.
        begin
            int pop_at = -1, vld_at = -1, npop = 0;
            drain_en = 1'b1; host_ready = 1'b1;
            push_byte(8'hA5, 1'b0);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (fifo_pop) npop++;
                if (fifo_pop && pop_at < 0) pop_at = i;
                if (host_valid && vld_at < 0) vld_at = i;
            end
            check("t1_latency", 32'(vld_at - pop_at), 32'd2);
            check("t1_npop",    32'(npop),            32'd1);
            check("t1_idle_vld", {31'd0, host_valid}, 32'd0);
            check("t1_sb_empty", 32'(sb_q.size()),    32'd0);
        end

        // Writes in ISSUE hold off the pop; the pop is retried afterwards.
        drain_en = 1'b0;
        push_byte(8'h10, 1'b0);
        drain_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rx_data_rdy = 1'b1;
            rx_wdata    = 8'h11 + 8'(i);
            sb_q.push_back(rx_wdata);
            @(negedge clk);
            check("t2_pop_held", {31'd0, fifo_pop}, 32'd0);
            @(posedge clk); #1;
        end
        rx_data_rdy = 1'b0;
        @(negedge clk);
        check("t2_pop_retry", {31'd0, fifo_pop}, 32'd1);
        wait_drain("t2_drain");

        // Host stalls in PRESENT: data held, no further pops.
        drain_en = 1'b0; host_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_byte(8'(i), 1'b0);
        drain_en = 1'b1;
        wait_valid("t3_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_vld",  {31'd0, host_valid}, 32'd1);
            check("t3_hold_data", {24'd0, host_data},  32'h01);
            check("t3_no_pop",    {31'd0, fifo_pop},   32'd0);
        end
        @(posedge clk); #1 host_ready = 1'b1;
        wait_drain("t3_drain");

        // Character timeout with draining disabled.
        drain_en = 1'b0;
        push_byte(8'h5A, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("t4_to_early", {31'd0, irq_timeout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t4_to_rise", {31'd0, irq_timeout}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rx_data_rdy = 1'b1; rx_wdata = 8'h5B; sb_q.push_back(8'h5B);
        @(negedge clk);
        check("t4_to_hold", {31'd0, irq_timeout}, 32'd1);
        @(posedge clk); #1 rx_data_rdy = 1'b0;
        @(negedge clk);
        check("t4_to_drop", {31'd0, irq_timeout}, 32'd0);
        drain_en = 1'b1;
        wait_drain("t4_drain");

        // Overflow: fill, drop three, clear, clear coincident with a drop.
        drain_en = 1'b0; host_ready = 1'b0;
        for (int i = 0; i < FDEP; i++) push_byte(8'h80 + 8'(i), 1'b0);
        @(negedge clk);
        check("t5_irq_data", {31'd0, irq_data},     32'd1);
        check("t5_no_ovf",   {31'd0, irq_overflow}, 32'd0);
        for (int i = 0; i < 3; i++) push_byte(8'hEE, 1'b0);
        @(negedge clk);
        check("t5_ovf",   {31'd0, irq_overflow}, 32'd1);
        check("t5_drops", {24'd0, drop_count},   32'd3);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("t5_clr_ovf",   {31'd0, irq_overflow}, 32'd0);
        check("t5_clr_drops", {24'd0, drop_count},   32'd0);
        push_byte(8'hEF, 1'b1);
        @(negedge clk);
        check("t5_both_ovf",   {31'd0, irq_overflow}, 32'd1);
        check("t5_both_drops", {24'd0, drop_count},   32'd1);

        // Reset while a byte is presented.
        drain_en = 1'b1;
        wait_valid("t6_valid");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t6_pre_to", {31'd0, irq_timeout}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("t6_valid_clr", {31'd0, host_valid},   32'd0);
        check("t6_irq_data",  {31'd0, irq_data},     32'd0);
        check("t6_irq_to",    {31'd0, irq_timeout},  32'd0);
        check("t6_irq_ovf",   {31'd0, irq_overflow}, 32'd0);
        check("t6_drops",     {24'd0, drop_count},   32'd0);
        repeat (5) @(negedge clk);
        check("t6_stay_idle", {31'd0, host_valid || fifo_pop}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_rx_fifo_drain_ctrl
